// File: rtl/vga_pkg.sv
// Shared VGA timing defaults (640x480@60), state/payload types and raster helpers.
package vga_pkg;

  localparam int unsigned DEF_H_ACTIVE = 640;
  localparam int unsigned DEF_H_FP     = 16;
  localparam int unsigned DEF_H_SYNC   = 96;
  localparam int unsigned DEF_H_BP     = 48;
  localparam int unsigned DEF_V_ACTIVE = 480;
  localparam int unsigned DEF_V_FP     = 10;
  localparam int unsigned DEF_V_SYNC   = 2;
  localparam int unsigned DEF_V_BP     = 33;
  localparam int unsigned DEF_CW       = 3;
  localparam int unsigned DEF_RD_LAT   = 1;
  localparam int unsigned DEF_CNT_W    = 16;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } vga_state_e;

  // Sync/enable bundle carried alongside the framebuffer read latency
  typedef struct packed {
    logic hs;
    logic vs;
    logic de;
  } vga_sync_t;

  function automatic int unsigned h_total(input int unsigned act, input int unsigned fp,
                                          input int unsigned sync, input int unsigned bp);
    return act + fp + sync + bp;
  endfunction

  function automatic int unsigned v_total(input int unsigned act, input int unsigned fp,
                                          input int unsigned sync, input int unsigned bp);
    return act + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Fixed-depth shift register with asynchronous clear to a programmable value.
module vga_delay_line #(
  parameter int unsigned     WIDTH   = 3,
  parameter int unsigned     DEPTH   = 1,
  parameter logic [WIDTH-1:0] CLR_VAL = '0
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_pipe [DEPTH];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) r_pipe[i] <= CLR_VAL;
    end else begin
      r_pipe[0] <= i_d;
      for (int unsigned i = 1; i < DEPTH; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  assign o_q = r_pipe[DEPTH-1];

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster walker: issues framebuffer addresses, then emits sync,
// data-enable and colour aligned after the framebuffer read latency.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FP     = DEF_H_FP,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FP     = DEF_V_FP,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BP     = DEF_V_BP,
  parameter bit          HS_POL   = 1'b0,
  parameter bit          VS_POL   = 1'b0,
  parameter int unsigned CW       = DEF_CW,
  parameter int unsigned RD_LAT   = DEF_RD_LAT,
  parameter int unsigned CNT_W    = DEF_CNT_W
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_en,
  input  logic               i_scale,
  input  logic [3*CW-1:0]    i_q,
  output logic [2*CNT_W-1:0] o_addr,
  output logic               o_addr_vld,
  output logic               o_hs,
  output logic               o_vs,
  output logic               o_de,
  output logic [CW-1:0]      o_r,
  output logic [CW-1:0]      o_g,
  output logic [CW-1:0]      o_b,
  output logic               o_frame_start,
  output logic               o_vblank
);

  localparam int unsigned H_TOTAL  = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int unsigned V_TOTAL  = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int unsigned HS_START = H_ACTIVE + H_FP;
  localparam int unsigned HS_END   = HS_START + H_SYNC;
  localparam int unsigned VS_START = V_ACTIVE + V_FP;
  localparam int unsigned VS_END   = VS_START + V_SYNC;
  localparam int unsigned QW       = 3 * CW;
  localparam int unsigned SW       = $bits(vga_sync_t);
  localparam vga_sync_t   SYNC_IDLE = '{hs: ~HS_POL, vs: ~VS_POL, de: 1'b0};

  vga_state_e         r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_cx, r_cy, w_cx_nxt, w_cy_nxt;
  logic               r_scale, w_scale_nxt;
  logic [2*CNT_W-1:0] r_addr, w_addr_nxt;
  logic               r_addr_vld, w_addr_vld_nxt;
  logic               r_frame_start, w_fs_nxt;
  logic               r_vblank, w_vblank_nxt;
  vga_sync_t          r_sync_a, w_sync_nxt, w_sync_dly;
  logic               r_hs, r_vs, r_de;
  logic [QW-1:0]      r_rgb;
  logic               w_line_end, w_frame_end, w_origin;

  assign w_line_end  = (r_cx == CNT_W'(H_TOTAL - 1));
  assign w_frame_end = w_line_end && (r_cy == CNT_W'(V_TOTAL - 1));
  assign w_origin    = (r_cx == '0) && (r_cy == '0);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next raster position and the addr-stage view of the current position
  always_comb begin
    w_state_nxt    = r_state;
    w_cx_nxt       = r_cx;
    w_cy_nxt       = r_cy;
    w_scale_nxt    = 1'b0;
    w_addr_nxt     = '0;
    w_addr_vld_nxt = 1'b0;
    w_fs_nxt       = 1'b0;
    w_vblank_nxt   = 1'b0;
    w_sync_nxt     = SYNC_IDLE;
    case (r_state)
      ST_IDLE: begin
        w_cx_nxt = '0;
        w_cy_nxt = '0;
        if (i_en) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (w_line_end) begin
          w_cx_nxt = '0;
          w_cy_nxt = w_frame_end ? '0 : r_cy + CNT_W'(1);
        end else begin
          w_cx_nxt = r_cx + CNT_W'(1);
        end
        if (w_frame_end && !i_en) w_state_nxt = ST_IDLE;
        // Mode is only sampled at the frame origin so a frame is never torn
        w_scale_nxt    = w_origin ? i_scale : r_scale;
        w_addr_nxt     = w_scale_nxt ? {r_cy >> 1, r_cx >> 1} : {r_cy, r_cx};
        w_addr_vld_nxt = (r_cx < CNT_W'(H_ACTIVE)) && (r_cy < CNT_W'(V_ACTIVE));
        w_fs_nxt       = w_origin;
        w_vblank_nxt   = (r_cy >= CNT_W'(V_ACTIVE));
        w_sync_nxt.hs  = ((r_cx >= CNT_W'(HS_START)) && (r_cx < CNT_W'(HS_END))) ? HS_POL : ~HS_POL;
        w_sync_nxt.vs  = ((r_cy >= CNT_W'(VS_START)) && (r_cy < CNT_W'(VS_END))) ? VS_POL : ~VS_POL;
        w_sync_nxt.de  = w_addr_vld_nxt;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Counters and address-stage registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cx          <= '0;
      r_cy          <= '0;
      r_scale       <= 1'b0;
      r_addr        <= '0;
      r_addr_vld    <= 1'b0;
      r_frame_start <= 1'b0;
      r_vblank      <= 1'b0;
      r_sync_a      <= SYNC_IDLE;
    end else begin
      r_cx          <= w_cx_nxt;
      r_cy          <= w_cy_nxt;
      r_scale       <= w_scale_nxt;
      r_addr        <= w_addr_nxt;
      r_addr_vld    <= w_addr_vld_nxt;
      r_frame_start <= w_fs_nxt;
      r_vblank      <= w_vblank_nxt;
      r_sync_a      <= w_sync_nxt;
    end
  end

  vga_delay_line #(
    .WIDTH  (SW),
    .DEPTH  (RD_LAT),
    .CLR_VAL(SYNC_IDLE)
  ) u_sync_dly (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_d    (r_sync_a),
    .o_q    (w_sync_dly)
  );

  // Output stage: q arrives together with the delayed sync/de for the same pixel
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_hs  <= ~HS_POL;
      r_vs  <= ~VS_POL;
      r_de  <= 1'b0;
      r_rgb <= '0;
    end else begin
      r_hs  <= w_sync_dly.hs;
      r_vs  <= w_sync_dly.vs;
      r_de  <= w_sync_dly.de;
      r_rgb <= w_sync_dly.de ? i_q : '0;
    end
  end

  assign o_addr        = r_addr;
  assign o_addr_vld    = r_addr_vld;
  assign o_frame_start = r_frame_start;
  assign o_vblank      = r_vblank;
  assign o_hs          = r_hs;
  assign o_vs          = r_vs;
  assign o_de          = r_de;
  assign o_r           = r_rgb[3*CW-1:2*CW];
  assign o_g           = r_rgb[2*CW-1:CW];
  assign o_b           = r_rgb[CW-1:0];

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen on a reduced 16x12 raster with RD_LAT = 3.
module tb_vga_timing_gen;

  // Raster: 16+2+4+3 = 25 clocks per line, 12+2+2+3 = 19 lines, 475 clocks per frame
  localparam int unsigned HA = 16, HF = 2, HSY = 4, HB = 3;
  localparam int unsigned VA = 12, VF = 2, VSY = 2, VB = 3;
  localparam int unsigned HT = 25, VT = 19, FT = 475;
  localparam int unsigned LAT = 3, CW = 3, CNT_W = 16;
  localparam int unsigned PIPE = LAT + 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              en = 1'b0;
  logic              scale = 1'b0;
  logic [3*CW-1:0]   q;
  logic [2*CNT_W-1:0] addr;
  logic              addr_vld, hs, vs, de, frame_start, vblank;
  logic [CW-1:0]     r, g, b;

  always #5 clk = ~clk;

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB),
    .HS_POL(1'b0), .VS_POL(1'b0), .CW(CW), .RD_LAT(LAT), .CNT_W(CNT_W)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_scale(scale), .i_q(q),
    .o_addr(addr), .o_addr_vld(addr_vld), .o_hs(hs), .o_vs(vs), .o_de(de),
    .o_r(r), .o_g(g), .o_b(b), .o_frame_start(frame_start), .o_vblank(vblank)
  );

  // Framebuffer model: returns addr[8:0] exactly LAT clocks after the address
  logic [2*CNT_W-1:0] fb_pipe [LAT];
  logic               force_ones = 1'b0;
  always @(posedge clk) begin
    fb_pipe[0] <= addr;
    for (int i = 1; i < LAT; i++) fb_pipe[i] <= fb_pipe[i-1];
  end
  assign q = force_ones ? 9'h1FF : fb_pipe[LAT-1][8:0];

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] q_addr [$];
  logic [8:0]  q_rgb  [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_hs"}, hs, 1'b1);
    check({tag, "_vs"}, vs, 1'b1);
    check({tag, "_de"}, de, 1'b0);
    check({tag, "_rgb"}, {r, g, b}, 9'h000);
    check({tag, "_addr"}, addr, 32'h0);
    check({tag, "_addr_vld"}, addr_vld, 1'b0);
    check({tag, "_frame_start"}, frame_start, 1'b0);
    check({tag, "_vblank"}, vblank, 1'b0);
  endtask

  // Expected active-area addresses and pixel colours for one frame
  task automatic push_frame(input bit x2, input bit ones);
    for (int y = 0; y < VA; y++)
      for (int x = 0; x < HA; x++) begin
        q_addr.push_back({16'(x2 ? y / 2 : y), 16'(x2 ? x / 2 : x)});
        q_rgb.push_back(ones ? 9'h1FF : 9'(x2 ? x / 2 : x));
      end
  endtask

  // Monitor state
  int cyc = 0, t_fs = 0, t_de_rise = -1000, t_hs_fall = 0, t_vs_fall = 0;
  int lx = 0, ly = 0, fcount = 0;
  bit have_fs = 1'b0, in_frame = 1'b0;
  logic prev_de = 1'b0, prev_hs = 1'b1, prev_vs = 1'b1;

  initial begin : monitor
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        prev_de = 1'b0; prev_hs = 1'b1; prev_vs = 1'b1;
        in_frame = 1'b0; have_fs = 1'b0;
      end else begin
        // Address stage
        if (frame_start) begin
          if (have_fs) check("frame_period", 64'(cyc - t_fs), 64'(FT));
          have_fs = 1'b1; t_fs = cyc; in_frame = 1'b1; lx = 0; ly = 0; fcount++;
        end
        if (in_frame) begin
          check("vblank", vblank, 1'(ly >= VA));
          check("addr_vld", addr_vld, 1'(lx < HA && ly < VA));
          if (fcount == 2 && lx == 9 && ly == 3) check("addr_2x_at_9_3", addr, {16'd1, 16'd4});
          if (lx == HT - 1) begin
            lx = 0;
            if (ly == VT - 1) in_frame = 1'b0;
            else ly++;
          end else lx++;
        end
        if (addr_vld) begin
          if (q_addr.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL addr_unexpected: got 0x%0h, expected no address", addr);
          end else check("addr", addr, q_addr.pop_front());
        end
        // Output stage
        if (de) begin
          if (q_rgb.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL rgb_unexpected: got 0x%0h, expected no pixel", {r, g, b});
          end else check("pixel_rgb", {r, g, b}, q_rgb.pop_front());
        end else check("blank_rgb", {r, g, b}, 9'h000);
        if (de && !prev_de) t_de_rise = cyc;
        if (!de && prev_de) check("de_width", 64'(cyc - t_de_rise), 64'(HA));
        if (!hs && prev_hs) begin
          t_hs_fall = cyc;
          if (cyc - t_de_rise < HT) check("hs_start", 64'(cyc - t_de_rise), 64'(HA + HF));
        end
        if (hs && !prev_hs) check("hs_width", 64'(cyc - t_hs_fall), 64'(HSY));
        if (!vs && prev_vs) begin
          t_vs_fall = cyc;
          check("vs_start", 64'(cyc - t_fs), 64'((VA + VF) * HT + PIPE));
        end
        if (vs && !prev_vs) check("vs_width", 64'(cyc - t_vs_fall), 64'(VSY * HT));
        prev_de = de; prev_hs = hs; prev_vs = vs;
      end
    end
  end

  task automatic wait_fs(input string name);
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!frame_start && k < FT + 10);
    check(name, frame_start, 1'b1);
  endtask

  // Release reset with en high; frame_start must appear on the second edge
  task automatic release_and_check_start(input string tag);
    int k = 0;
    rst_n = 1'b1;
    en    = 1'b1;
    do begin
      @(negedge clk);
      k++;
    end while (!frame_start && k < 10);
    check({tag, "_fs_latency"}, 64'(k), 64'd2);
    @(negedge clk);
    check({tag, "_fs_once"}, frame_start, 1'b0);
  endtask

  task automatic check_idle(input string tag);
    bit bad = 1'b0;
    repeat (60) begin
      @(negedge clk);
      if (frame_start || addr_vld || vblank || de || !hs || !vs || addr != '0 || {r, g, b} != '0)
        bad = 1'b1;
    end
    check({tag, "_idle_outputs"}, bad, 1'b0);
    check({tag, "_addr_drained"}, 64'(q_addr.size()), 64'd0);
    check({tag, "_rgb_drained"}, 64'(q_rgb.size()), 64'd0);
  endtask

  initial begin : stim
    repeat (3) @(negedge clk);
    #1;
    check_reset_values("por");

    // Frames 0..2: native, 2x, native; en dropped mid-frame 2
    push_frame(1'b0, 1'b0);
    push_frame(1'b1, 1'b0);
    push_frame(1'b0, 1'b0);
    release_and_check_start("start0");
    repeat (5 * HT - 2) @(negedge clk);
    scale = 1'b1;
    wait_fs("frame1_start");
    repeat (5 * HT) @(negedge clk);
    scale = 1'b0;
    wait_fs("frame2_start");
    repeat (6 * HT) @(negedge clk);
    en = 1'b0;
    repeat ((VT - 6) * HT + 20) @(negedge clk);
    check_idle("stop");
    have_fs = 1'b0;

    // Frame 3: restart from idle with q stuck at all-ones, reset mid-line
    push_frame(1'b0, 1'b1);
    force_ones = 1'b1;
    en = 1'b1;
    wait_fs("frame3_start");
    repeat (8 * HT + 7) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_reset_values("midrst");
    q_addr.delete();
    q_rgb.delete();
    force_ones = 1'b0;
    repeat (3) @(negedge clk);

    // Frame 4: restart after reset, single frame
    push_frame(1'b0, 1'b0);
    #1;
    release_and_check_start("start4");
    en = 1'b0;
    repeat (FT + 20) @(negedge clk);
    check_idle("end");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
